serial_config_port: RTL and testbench

- Parametrised successor to the fixed-map serial programmer. One register file of NUM_REGS x DATA_W bits, loaded over a 3-wire serial port (SCLK/SDI/CS) plus an SDO readback line.
- The serial pins are oversampled in the CLK_24M domain, so the block runs on a single clock.
- Exports the flat register image to the analog-trim and converter-control fields, with a one-cycle update strobe per committed write.

---
 rtl/serial_config_port.sv | 208 ++++++++++++++++++++
 tb/tb_serial_config_port.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_config_port.sv
// serial_config_port
// Register file of NUM_REGS x DATA_W bits written and read over a 3-wire
// serial port (SCLK/SDI/CS) with an SDO readback line. The serial pins are
// oversampled in the CLK_24M domain, so everything runs on one clock.
// Frame: RW bit (1=read), ADDR_W address bits, DATA_W data bits, MSB first,
// sampled on SCLK rising edges. DATA_W >= 2 and ADDR_W >= 1 are assumed.
module serial_config_port #(
    parameter int NUM_REGS    = 16,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       CLK_24M,
    input  logic                       reset,
    input  logic                       SCLK,
    input  logic                       SDI,
    input  logic                       CS,
    output logic                       SDO,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       reg_update,
    output logic [ADDR_W-1:0]          update_addr,
    output logic                       frame_error,
    output logic                       addr_error
);

    localparam int CMD_LEN   = 1 + ADDR_W;
    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [ADDR_W:0] NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_CS} state_t;

    // Input synchronisers and edge-detect history
    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] sdi_sync_reg;
    logic [SYNC_STAGES-1:0] cs_sync_reg;
    logic                   sclk_hist_reg;
    logic                   cs_hist_reg;

    logic sclk_s, sdi_s, cs_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    // Frame engine state
    state_t              state_reg;
    logic [CNT_W-1:0]    bit_cnt_reg;
    logic [ADDR_W-1:0]   cmd_sr_reg;
    logic [DATA_W-1:0]   data_sr_reg;
    logic                rw_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                addr_bad_reg;
    logic                over_len_reg;
    logic [DATA_W-1:0]   rd_sr_reg;
    logic                sdo_reg;
    logic                reg_update_reg;
    logic [ADDR_W-1:0]   update_addr_reg;
    logic                frame_error_reg;
    logic                addr_error_reg;
    logic [DATA_W-1:0]   regs_reg [NUM_REGS];

    // Command word as it looks once the current SDI bit is shifted in
    logic [ADDR_W:0]     cmd_next;
    logic [ADDR_W-1:0]   addr_next;
    logic                addr_next_bad;
    logic [DATA_W-1:0]   rd_load;

    assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync_reg[SYNC_STAGES-1];
    assign cs_s   = cs_sync_reg[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_hist_reg;
    assign sclk_fall = ~sclk_s & sclk_hist_reg;
    assign cs_fall   = ~cs_s & cs_hist_reg;
    assign cs_rise   = cs_s & ~cs_hist_reg;

    assign cmd_next      = {cmd_sr_reg, sdi_s};
    assign addr_next     = cmd_next[ADDR_W-1:0];
    assign addr_next_bad = ({1'b0, addr_next} >= NUM_REGS_EXT);

    // Readback value for the address being latched; out-of-range reads give 0
    always_comb begin
        rd_load = '0;
        if (!addr_next_bad) begin
            rd_load = regs_reg[addr_next];
        end
    end

    // Synchronise the serial pins; reset values look like an idle bus
    always_ff @(posedge CLK_24M or posedge reset) begin
        if (reset) begin
            sclk_sync_reg <= '0;
            sdi_sync_reg  <= '0;
            cs_sync_reg   <= '1;
            sclk_hist_reg <= 1'b0;
            cs_hist_reg   <= 1'b1;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], SCLK};
            sdi_sync_reg  <= {sdi_sync_reg[SYNC_STAGES-2:0], SDI};
            cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], CS};
            sclk_hist_reg <= sclk_s;
            cs_hist_reg   <= cs_s;
        end
    end

    // Frame FSM, register file, readback shifter and status pulses
    always_ff @(posedge CLK_24M or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            bit_cnt_reg     <= '0;
            cmd_sr_reg      <= '0;
            data_sr_reg     <= '0;
            rw_reg          <= 1'b0;
            addr_reg        <= '0;
            addr_bad_reg    <= 1'b0;
            over_len_reg    <= 1'b0;
            rd_sr_reg       <= '0;
            sdo_reg         <= 1'b0;
            reg_update_reg  <= 1'b0;
            update_addr_reg <= '0;
            frame_error_reg <= 1'b0;
            addr_error_reg  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= RESET_VAL[i*DATA_W +: DATA_W];
            end
        end else begin
            reg_update_reg  <= 1'b0;
            frame_error_reg <= 1'b0;
            addr_error_reg  <= 1'b0;

            if (state_reg == IDLE) begin
                if (cs_fall) begin
                    bit_cnt_reg  <= '0;
                    cmd_sr_reg   <= '0;
                    data_sr_reg  <= '0;
                    over_len_reg <= 1'b0;
                    sdo_reg      <= 1'b0;
                    state_reg    <= CMD;
                end
            end else if (cs_rise) begin
                // CS release ends the frame and wins over any SCLK edge
                state_reg <= IDLE;
                sdo_reg   <= 1'b0;
                if (state_reg == WAIT_CS && !over_len_reg) begin
                    if (!rw_reg && !addr_bad_reg) begin
                        regs_reg[addr_reg] <= data_sr_reg;
                        reg_update_reg     <= 1'b1;
                        update_addr_reg    <= addr_reg;
                    end
                end else begin
                    frame_error_reg <= 1'b1;
                end
            end else begin
                case (state_reg)
                    CMD: begin
                        if (sclk_rise) begin
                            cmd_sr_reg  <= cmd_next[ADDR_W-1:0];
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            if (bit_cnt_reg == CNT_W'(CMD_LEN - 1)) begin
                                rw_reg         <= cmd_next[ADDR_W];
                                addr_reg       <= addr_next;
                                addr_bad_reg   <= addr_next_bad;
                                addr_error_reg <= addr_next_bad;
                                rd_sr_reg      <= cmd_next[ADDR_W] ? rd_load : '0;
                                state_reg      <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (sclk_rise) begin
                            data_sr_reg <= {data_sr_reg[DATA_W-2:0], sdi_s};
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            if (bit_cnt_reg == CNT_W'(FRAME_LEN - 1)) begin
                                sdo_reg   <= 1'b0;
                                state_reg <= WAIT_CS;
                            end
                        end else if (sclk_fall && rw_reg) begin
                            // Present the next readback bit on each falling edge
                            sdo_reg   <= rd_sr_reg[DATA_W-1];
                            rd_sr_reg <= {rd_sr_reg[DATA_W-2:0], 1'b0};
                        end
                    end
                    WAIT_CS: begin
                        if (sclk_rise) begin
                            over_len_reg <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign regs_flat[gi*DATA_W +: DATA_W] = regs_reg[gi];
        end
    endgenerate

    assign SDO         = sdo_reg;
    assign reg_update  = reg_update_reg;
    assign update_addr = update_addr_reg;
    assign frame_error = frame_error_reg;
    assign addr_error  = addr_error_reg;

endmodule

// File: tb/tb_serial_config_port.sv
// Bench for serial_config_port: two instances share the serial pins.
// dut_a: 12 regs x 8 bits (frame 13 bits), dut_b: 32 regs x 12 bits (frame
// 18 bits). A frame sized for one instance is always short or long for the
// other, so it never commits there.
module tb_serial_config_port;

    localparam int NR_A = 12, AW_A = 4, DW_A = 8, FL_A = 13;
    localparam int NR_B = 32, AW_B = 5, DW_B = 12, FL_B = 18;
    localparam logic [NR_A*DW_A-1:0] RST_A = 96'hA5;
    localparam logic [NR_B*DW_B-1:0] RST_B = {12'h123, 360'h0, 12'hFED};
    localparam int HALF = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0;
    logic sdi = 1'b0;
    logic cs = 1'b1;

    logic                   sdo_a, upd_a, ferr_a, aerr_a;
    logic [NR_A*DW_A-1:0]   flat_a;
    logic [AW_A-1:0]        uaddr_a;
    logic                   sdo_b, upd_b, ferr_b, aerr_b;
    logic [NR_B*DW_B-1:0]   flat_b;
    logic [AW_B-1:0]        uaddr_b;

    always #5 clk = ~clk;

    serial_config_port #(.NUM_REGS(NR_A), .ADDR_W(AW_A), .DATA_W(DW_A),
                         .SYNC_STAGES(2), .RESET_VAL(RST_A)) dut_a (
        .CLK_24M(clk), .reset(rst), .SCLK(sclk), .SDI(sdi), .CS(cs),
        .SDO(sdo_a), .regs_flat(flat_a), .reg_update(upd_a),
        .update_addr(uaddr_a), .frame_error(ferr_a), .addr_error(aerr_a));

    serial_config_port #(.NUM_REGS(NR_B), .ADDR_W(AW_B), .DATA_W(DW_B),
                         .SYNC_STAGES(3), .RESET_VAL(RST_B)) dut_b (
        .CLK_24M(clk), .reset(rst), .SCLK(sclk), .SDI(sdi), .CS(cs),
        .SDO(sdo_b), .regs_flat(flat_b), .reg_update(upd_b),
        .update_addr(uaddr_b), .frame_error(ferr_b), .addr_error(aerr_b));

    typedef struct {
        logic [AW_B-1:0] addr;
        logic [DW_B-1:0] data;
    } upd_t;

    typedef struct {
        logic       rw;
        logic [4:0] addr;
        logic [7:0] data;
        int         nbits;
        logic       exp_upd;
        logic       exp_ferr;
        logic       exp_aerr;
        logic       chk_rd;
        logic [7:0] exp_rd;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cnt_upd_a = 0, cnt_ferr_a = 0, cnt_aerr_a = 0;
    int cnt_upd_b = 0, cnt_ferr_b = 0, cnt_aerr_b = 0;
    upd_t exp_qa[$];
    upd_t exp_qb[$];
    logic [DW_A-1:0] model_a [NR_A];
    logic [DW_B-1:0] model_b [NR_B];
    logic cap_a [32];
    logic cap_b [32];
    vec_t vecs [16];

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock step; outputs sampled 1 time unit after the edge.
    // Commit pulses are matched against the scoreboard queues here.
    task automatic tick();
        upd_t u;
        @(posedge clk);
        #1;
        if (upd_a) begin
            cnt_upd_a++;
            check("upd_a_queue", 384'(exp_qa.size() > 0), 384'(1));
            if (exp_qa.size() > 0) begin
                u = exp_qa.pop_front();
                check("upd_addr_a", 384'(uaddr_a), 384'(u.addr));
                check("upd_data_a", 384'(flat_a[u.addr*DW_A +: DW_A]), 384'(u.data));
            end
        end
        if (upd_b) begin
            cnt_upd_b++;
            check("upd_b_queue", 384'(exp_qb.size() > 0), 384'(1));
            if (exp_qb.size() > 0) begin
                u = exp_qb.pop_front();
                check("upd_addr_b", 384'(uaddr_b), 384'(u.addr));
                check("upd_data_b", 384'(flat_b[u.addr*DW_B +: DW_B]), 384'(u.data));
            end
        end
        if (ferr_a) cnt_ferr_a++;
        if (aerr_a) cnt_aerr_a++;
        if (ferr_b) cnt_ferr_b++;
        if (aerr_b) cnt_aerr_b++;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_counts();
        cnt_upd_a = 0; cnt_ferr_a = 0; cnt_aerr_a = 0;
        cnt_upd_b = 0; cnt_ferr_b = 0; cnt_aerr_b = 0;
    endtask

    // One SCLK period; SDO is captured just before the rising edge
    task automatic send_bit(input logic b, input int idx);
        sdi = b;
        wait_n(HALF);
        cap_a[idx] = sdo_a;
        cap_b[idx] = sdo_b;
        sclk = 1'b1;
        wait_n(HALF);
        sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] frame, input int flen, input int nbits);
        logic b;
        clear_counts();
        for (int i = 0; i < 32; i++) begin
            cap_a[i] = 1'b0;
            cap_b[i] = 1'b0;
        end
        cs = 1'b0;
        wait_n(HALF);
        for (int i = 0; i < nbits; i++) begin
            b = (i < flen) ? frame[flen-1-i] : 1'b0;
            send_bit(b, i);
        end
        wait_n(HALF);
        cs = 1'b1;
        sdi = 1'b0;
        wait_n(3 * HALF);
    endtask

    function automatic logic [31:0] frame_a(input logic rw, input logic [4:0] addr, input logic [7:0] data);
        return {19'b0, rw, addr[3:0], data};
    endfunction

    function automatic logic [31:0] frame_b(input logic rw, input logic [4:0] addr, input logic [11:0] data);
        return {14'b0, rw, addr, data};
    endfunction

    function automatic logic [NR_A*DW_A-1:0] img_a();
        logic [NR_A*DW_A-1:0] r;
        for (int i = 0; i < NR_A; i++) r[i*DW_A +: DW_A] = model_a[i];
        return r;
    endfunction

    function automatic logic [NR_B*DW_B-1:0] img_b();
        logic [NR_B*DW_B-1:0] r;
        for (int i = 0; i < NR_B; i++) r[i*DW_B +: DW_B] = model_b[i];
        return r;
    endfunction

    task automatic reset_models();
        for (int i = 0; i < NR_A; i++) model_a[i] = RST_A[i*DW_A +: DW_A];
        for (int i = 0; i < NR_B; i++) model_b[i] = RST_B[i*DW_B +: DW_B];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rd8;
        logic [11:0] rd12;
        logic        rw;
        logic [4:0]  addr;
        logic [11:0] data;
        int          nb, sel;
        logic        e_upd, e_ferr;
        logic [11:0] e_rd;

        //             rw    addr   data   bits upd   ferr  aerr  chk   rd
        vecs[0]  = '{1'b0, 5'd3,  8'h5C, 13, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 5'd3,  8'h00, 13, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5C};
        vecs[2]  = '{1'b0, 5'd2,  8'hFF,  9, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 5'd2,  8'hFF, 14, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 5'd15, 8'h77, 13, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 5'd13, 8'h00, 13, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};
        vecs[6]  = '{1'b0, 5'd2,  8'h81, 13, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 5'd0,  8'h00, 13, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[8]  = '{1'b0, 5'd11, 8'hC3, 13, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{1'b1, 5'd11, 8'h00, 13, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3};
        vecs[10] = '{1'b1, 5'd12, 8'h00, 15, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 5'd0,  8'h3C, 13, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 5'd5,  8'h99,  4, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[13] = '{1'b0, 5'd5,  8'h99,  0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[14] = '{1'b1, 5'd2,  8'h00, 12, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[15] = '{1'b0, 5'd12, 8'hEE, 14, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};

        reset_models();

        // Reset state, during and after reset
        wait_n(4);
        check("reset_flat_a", 384'(flat_a), 384'(RST_A));
        check("reset_flat_b", 384'(flat_b), 384'(RST_B));
        check("reset_sdo", 384'({sdo_a, sdo_b}), 384'(0));
        check("reset_pulses", 384'({upd_a, ferr_a, aerr_a, upd_b, ferr_b, aerr_b}), 384'(0));
        check("reset_uaddr", 384'({uaddr_a, uaddr_b}), 384'(0));
        rst = 1'b0;
        clear_counts();
        wait_n(10);
        check("idle_pulses", 384'(cnt_upd_a + cnt_ferr_a + cnt_aerr_a + cnt_upd_b + cnt_ferr_b + cnt_aerr_b), 384'(0));
        check("idle_flat_a", 384'(flat_a), 384'(img_a()));

        // Table-driven frames against dut_a
        for (int v = 0; v < 16; v++) begin
            if (vecs[v].exp_upd) begin
                exp_qa.push_back('{vecs[v].addr, {4'b0, vecs[v].data}});
                model_a[vecs[v].addr] = vecs[v].data;
            end
            send_frame(frame_a(vecs[v].rw, vecs[v].addr, vecs[v].data), FL_A, vecs[v].nbits);
            rd8 = '0;
            for (int k = 0; k < DW_A; k++) rd8 = {rd8[6:0], cap_a[1 + AW_A + k]};
            $display("vec %0d: rw=%0d addr=%0d data=%h bits=%0d upd=%0d ferr=%0d aerr=%0d sdo=%h",
                     v, vecs[v].rw, vecs[v].addr, vecs[v].data, vecs[v].nbits,
                     cnt_upd_a, cnt_ferr_a, cnt_aerr_a, rd8);
            check("vec_upd", 384'(cnt_upd_a), 384'(vecs[v].exp_upd));
            check("vec_ferr", 384'(cnt_ferr_a), 384'(vecs[v].exp_ferr));
            check("vec_aerr", 384'(cnt_aerr_a), 384'(vecs[v].exp_aerr));
            check("vec_flat_a", 384'(flat_a), 384'(img_a()));
            check("vec_sdo_idle", 384'(sdo_a), 384'(0));
            check("vec_queue_a", 384'(exp_qa.size()), 384'(0));
            if (vecs[v].chk_rd) check("vec_rd", 384'(rd8), 384'(vecs[v].exp_rd));
        end
        check("phase_a_flat_b", 384'(flat_b), 384'(img_b()));
        check("phase_a_upd_b", 384'(exp_qb.size()), 384'(0));

        // Reset in the middle of the data phase of a write to addr 1
        clear_counts();
        cs = 1'b0;
        wait_n(HALF);
        for (int i = 0; i < 8; i++) send_bit(frame_a(1'b0, 5'd1, 8'h6E) >> (FL_A - 1 - i), i);
        rst = 1'b1;
        wait_n(2);
        cs = 1'b1;
        sdi = 1'b0;
        wait_n(4);
        rst = 1'b0;
        reset_models();
        wait_n(2 * HALF);
        $display("reset mid-frame: flat_a=%h upd=%0d ferr=%0d", flat_a, cnt_upd_a, cnt_ferr_a);
        check("rst_mid_flat_a", 384'(flat_a), 384'(RST_A));
        check("rst_mid_flat_b", 384'(flat_b), 384'(RST_B));
        check("rst_mid_pulses", 384'(cnt_upd_a + cnt_ferr_a + cnt_aerr_a + cnt_upd_b + cnt_ferr_b + cnt_aerr_b), 384'(0));
        check("rst_mid_uaddr", 384'(uaddr_a), 384'(0));

        exp_qa.push_back('{5'd1, 12'h03A});
        model_a[1] = 8'h3A;
        send_frame(frame_a(1'b0, 5'd1, 8'h3A), FL_A, FL_A);
        $display("write after reset: addr=1 data=3a upd=%0d ferr=%0d", cnt_upd_a, cnt_ferr_a);
        check("post_rst_upd", 384'(cnt_upd_a), 384'(1));
        check("post_rst_ferr", 384'(cnt_ferr_a), 384'(0));
        check("post_rst_flat_a", 384'(flat_a), 384'(img_a()));

        // Random frames against dut_b, checked with the reference model
        for (int f = 0; f < 40; f++) begin
            rw   = 1'($urandom_range(0, 1));
            addr = 5'($urandom_range(0, NR_B - 1));
            data = 12'($urandom_range(0, 4095));
            sel  = $urandom_range(0, 4);
            nb   = (sel == 0) ? FL_B - 1 : (sel == 1) ? FL_B + 1 : FL_B;
            e_upd  = !rw && (nb == FL_B);
            e_ferr = (nb != FL_B);
            e_rd   = model_b[addr];
            if (e_upd) begin
                exp_qb.push_back('{addr, data});
                model_b[addr] = data;
            end
            send_frame(frame_b(rw, addr, data), FL_B, nb);
            rd12 = '0;
            for (int k = 0; k < DW_B; k++) rd12 = {rd12[10:0], cap_b[1 + AW_B + k]};
            $display("rand %0d: rw=%0d addr=%0d data=%h bits=%0d upd=%0d ferr=%0d sdo=%h",
                     f, rw, addr, data, nb, cnt_upd_b, cnt_ferr_b, rd12);
            check("rand_upd", 384'(cnt_upd_b), 384'(e_upd));
            check("rand_ferr", 384'(cnt_ferr_b), 384'(e_ferr));
            check("rand_aerr", 384'(cnt_aerr_b), 384'(0));
            check("rand_flat_b", 384'(flat_b), 384'(img_b()));
            if (rw && nb >= FL_B) check("rand_rd", 384'(rd12), 384'(e_rd));
        end
        check("end_queue_b", 384'(exp_qb.size()), 384'(0));
        check("end_flat_a", 384'(flat_a), 384'(img_a()));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
